// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receiver for 8N1 frames, or 8 data bits + parity + 1 stop
//   bit, sent LSB first. The line is synchronized, every bit is sampled at its
//   centre, and parity and stop bit are checked. Each received byte is
//   presented with a one-cycle valid strobe.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   rx         : serial line, asynchronous to clk, idles high
//   pen        : parity enable, latched at start-bit detect
//   peven      : 1 = even parity, 0 = odd parity, latched at start-bit detect
//   dout       : last received byte
//   valid      : one-cycle strobe, dout and the error flags were just updated
//   busy       : high from start-bit detect until the mid-stop sample
//   parity_err : parity mismatch on the last frame (0 when parity is disabled)
//   frame_err  : stop bit sampled low on the last frame
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       pen,
  input  logic       peven,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err
);

  // Rounded clocks per oversample tick.
  localparam int TICK_DIV      = BAUDRATE * OVERSAMPLE;
  localparam int SAMPLE_CYCLES = (CLK_FREQ_HZ + TICK_DIV / 2) / TICK_DIV;
  localparam int TICK_W        = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int SUB_W         = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF  = SUB_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Expected parity bit for a data byte.
  function automatic logic parity_bit(input logic [7:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

  state_t            state_r, state_s;
  logic              rx_meta_r, rx_sync_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              stick_s, tick_clr_s;
  logic [SUB_W-1:0]  sub_cnt_r, sub_cnt_s;
  logic [2:0]        bit_idx_r, bit_idx_s;
  logic [7:0]        shift_r, shift_s;
  logic              pen_r, pen_s, peven_r, peven_s, perr_r, perr_s;
  logic [7:0]        dout_s;
  logic              valid_s, busy_s, parity_err_s, frame_err_s;

  assign stick_s = (tick_cnt_r == TICK_LAST);

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Oversample tick counter, restarted at start-bit detect to align ticks to the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
    end else if (tick_clr_s || stick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      sub_cnt_r  <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      pen_r      <= 1'b0;
      peven_r    <= 1'b0;
      perr_r     <= 1'b0;
      dout       <= 8'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_r    <= state_s;
      sub_cnt_r  <= sub_cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      pen_r      <= pen_s;
      peven_r    <= peven_s;
      perr_r     <= perr_s;
      dout       <= dout_s;
      valid      <= valid_s;
      busy       <= busy_s;
      parity_err <= parity_err_s;
      frame_err  <= frame_err_s;
    end
  end

  // Next-state and next-output logic of the frame FSM.
  always_comb begin
    state_s      = state_r;
    tick_clr_s   = 1'b0;
    sub_cnt_s    = sub_cnt_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    pen_s        = pen_r;
    peven_s      = peven_r;
    perr_s       = perr_r;
    dout_s       = dout;
    valid_s      = 1'b0;
    busy_s       = busy;
    parity_err_s = parity_err;
    frame_err_s  = frame_err;

    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_s    = START;
          busy_s     = 1'b1;
          tick_clr_s = 1'b1;
          sub_cnt_s  = '0;
          bit_idx_s  = 3'd0;
          perr_s     = 1'b0;
          pen_s      = pen;
          peven_s    = peven;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (stick_s && (sub_cnt_r == SUB_HALF)) begin
          sub_cnt_s = '0;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_sync_r) begin
            state_s = IDLE;
            busy_s  = 1'b0;
          end else begin
            state_s = DATA;
          end
        end else if (stick_s) begin
          sub_cnt_s = sub_cnt_r + SUB_W'(1);
        end else begin
          sub_cnt_s = sub_cnt_r;
        end
      end

      DATA: begin
        if (stick_s && (sub_cnt_r == SUB_LAST)) begin
          sub_cnt_s = '0;
          shift_s   = {rx_sync_r, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = pen_r ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end else if (stick_s) begin
          sub_cnt_s = sub_cnt_r + SUB_W'(1);
        end else begin
          sub_cnt_s = sub_cnt_r;
        end
      end

      PARITY: begin
        if (stick_s && (sub_cnt_r == SUB_LAST)) begin
          sub_cnt_s = '0;
          perr_s    = rx_sync_r ^ parity_bit(shift_r, peven_r);
          state_s   = STOP;
        end else if (stick_s) begin
          sub_cnt_s = sub_cnt_r + SUB_W'(1);
        end else begin
          sub_cnt_s = sub_cnt_r;
        end
      end

      STOP: begin
        // Frame completes at mid stop bit so a directly following start bit is seen.
        if (stick_s && (sub_cnt_r == SUB_LAST)) begin
          sub_cnt_s    = '0;
          dout_s       = shift_r;
          parity_err_s = pen_r & perr_r;
          frame_err_s  = ~rx_sync_r;
          valid_s      = 1'b1;
          busy_s       = 1'b0;
          state_s      = rx_sync_r ? IDLE : WAIT_HIGH;
        end else if (stick_s) begin
          sub_cnt_s = sub_cnt_r + SUB_W'(1);
        end else begin
          sub_cnt_s = sub_cnt_r;
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new frame is accepted.
        if (rx_sync_r) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  // One clock = 100 time units, one ideal bit = 16 clocks.
  localparam int CLK_HALF = 50;
  localparam int BIT_T    = 1600;
  localparam int BIT_FAST = 1568;
  localparam int BIT_SLOW = 1632;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       pen;
  logic       peven;
  logic [7:0] dout;
  logic       valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  int   valid_cnt = 0;

  uart_receiver #(
    .CLK_FREQ_HZ(1600000),
    .BAUDRATE   (100000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .pen       (pen),
    .peven     (peven),
    .dout      (dout),
    .valid     (valid),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #CLK_HALF clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #10;
  endtask

  // Serial sender; leaves rx at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit, input int bit_t);
    rx = 1'b0;
    #bit_t;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 4) begin
        #(bit_t / 2);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        #(bit_t - bit_t / 2);
      end else begin
        #bit_t;
      end
    end
    if (use_par) begin
      rx = par_bit;
      #bit_t;
    end
    rx = stop_bit;
    #bit_t;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  // Scoreboard: every valid pops one expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst && valid) begin
      valid_cnt++;
      chk("valid_expected", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int v;
    rst   = 1'b1;
    rx    = 1'b1;
    pen   = 1'b0;
    peven = 1'b0;
    #20;
    rst = 1'b0;
    #210;
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    idle(5);

    // 0xA5, no parity, ideal timing.
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_T);
    drain("drain_a5");
    idle(5);
    chk("busy_after_a5", {31'd0, busy}, 32'd0);
    chk("valid_count_a5", valid_cnt, 32'd1);
    idle(10);

    // Parity: even/good, even/bad, odd/good.
    pen   = 1'b1;
    peven = 1'b1;
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, BIT_T);
    drain("drain_even_ok");
    idle(5);
    push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, BIT_T);
    drain("drain_even_bad");
    idle(5);
    peven = 1'b0;
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, BIT_T);
    drain("drain_odd_ok");
    idle(10);
    pen = 1'b0;

    // Start-bit glitch of 5 clocks.
    v  = valid_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(11);
    chk("busy_after_glitch", {31'd0, busy}, 32'd0);
    idle(30);
    chk("no_valid_glitch", valid_cnt, v);
    push(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, BIT_T);
    drain("drain_7e");
    idle(10);

    // Framing error followed by a held-low line.
    push(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, BIT_T);
    drain("drain_55_ferr");
    v = valid_cnt;
    idle(64);
    rx = 1'b1;
    idle(20);
    chk("no_valid_break", valid_cnt, v);
    push(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, BIT_T);
    drain("drain_01");
    idle(10);

    // Back-to-back frames with a fast and then a slow sender.
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, BIT_FAST);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, BIT_FAST);
    drain("drain_fast");
    idle(20);
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, BIT_SLOW);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, BIT_SLOW);
    drain("drain_slow");
    idle(20);

    // Reset during D3 of 0x81 abandons the frame.
    v  = valid_cnt;
    rx = 1'b0;
    #BIT_T;
    rx = 1'b1;
    #BIT_T;
    rx = 1'b0;
    #BIT_T;
    #BIT_T;
    #(BIT_T / 2);
    rst = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    idle(3);
    rx  = 1'b1;
    rst = 1'b1;
    idle(30);
    chk("no_valid_after_rst", valid_cnt, v);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, BIT_T);
    drain("drain_81");
    idle(10);
    chk("valid_once_81", valid_cnt, v + 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
